// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Writer side of the byte-addressable instruction memory. A host pushes a
// framed byte stream; the loader writes the payload bytes to consecutive
// addresses starting at BASE_ADDR, verifies an 8-bit additive checksum and
// keeps the CPU in reset until a good image has been loaded.
//
// Frame on the stream:
//   4 length bytes, big-endian (MSB first) = N
//   N payload bytes, written to BASE_ADDR + k in arrival order
//   1 checksum byte = (sum of payload bytes) mod 256
//
// Handshake (valid/ready): a byte moves on a rising clk edge where
// in_valid && in_ready are both 1. in_ready is a pure function of the FSM
// state (LEN, DATA, CSUM) and never looks at in_valid. A byte held on
// in_data while in_ready is 0 is simply not consumed; the host may keep it
// there or withdraw it.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   start      in   1-cycle pulse, begin a new frame (IDLE/DONE/ERR only)
//   in_valid   in   in_data carries a byte
//   in_data    in   [7:0] stream byte
//   in_ready   out  loader accepts a byte this cycle
//   we         out  instruction memory byte write enable (1-cycle pulse)
//   waddr      out  [31:0] byte address of the write
//   wdata      out  [7:0] byte to write
//   cpu_hold   out  1 = CPU held in reset
//   busy       out  frame in progress (LEN, DATA or CSUM)
//   done       out  last frame loaded with a good checksum (sticky)
//   err        out  last frame rejected (sticky)
//   byte_cnt   out  [31:0] payload bytes written in the current/last frame
//   state_dbg  out  [2:0] current FSM state, for observation only
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_BYTES = 4096,
  parameter bit          HOLD_RST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [7:0]  wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] byte_cnt,
  output logic [2:0]  state_dbg
);

  // FSM encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEN  = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_CSUM = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;
  localparam logic [2:0] ST_ERR  = 3'd5;

  logic [2:0]  state;
  logic [1:0]  len_idx;     // which length byte is expected next (0..3)
  logic [23:0] len_shift;   // first three length bytes, MSB first
  logic [31:0] len_n;       // payload length of the current frame
  logic [7:0]  sum;         // running payload sum, wraps mod 256

  logic        xfer;
  logic [31:0] len_full;
  logic        len_bad;
  logic [31:0] byte_cnt_next;
  logic        last_payload;

  // A byte transfers only when both sides agree on this edge.
  assign xfer = in_valid && in_ready;

  // The complete length as it will look once the 4th byte lands.
  assign len_full = {len_shift, in_data};

  // Oversized lengths and lengths that are not whole 32-bit instructions
  // are rejected before anything is written.
  assign len_bad = (len_full > MAX_BYTES) || (len_full[1:0] != 2'b00);

  assign byte_cnt_next = byte_cnt + 32'd1;
  assign last_payload  = (byte_cnt_next == len_n);

  // Ready and busy both follow the "frame in progress" states directly.
  assign in_ready  = (state == ST_LEN) || (state == ST_DATA) || (state == ST_CSUM);
  assign busy      = in_ready;
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      len_idx   <= 2'd0;
      len_shift <= 24'd0;
      len_n     <= 32'd0;
      sum       <= 8'd0;
      we        <= 1'b0;
      waddr     <= 32'd0;
      wdata     <= 8'd0;
      cpu_hold  <= HOLD_RST;
      done      <= 1'b0;
      err       <= 1'b0;
      byte_cnt  <= 32'd0;
    end else begin
      // we is a single-cycle pulse; only the DATA branch raises it.
      we <= 1'b0;

      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state     <= ST_LEN;
            len_idx   <= 2'd0;
            len_shift <= 24'd0;
            len_n     <= 32'd0;
            sum       <= 8'd0;
            byte_cnt  <= 32'd0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_hold  <= 1'b1;
          end
        end

        ST_LEN: begin
          if (xfer) begin
            len_shift <= {len_shift[15:0], in_data};
            len_idx   <= len_idx + 2'd1;
            if (len_idx == 2'd3) begin
              len_n <= len_full;
              if (len_bad) begin
                state <= ST_ERR;
                err   <= 1'b1;
              end else if (len_full == 32'd0) begin
                // Empty image: only the checksum byte (expected 00) follows.
                state <= ST_CSUM;
              end else begin
                state <= ST_DATA;
              end
            end
          end
        end

        ST_DATA: begin
          if (xfer) begin
            // Registered write port: the write appears the cycle after the
            // handshake. Address arithmetic wraps mod 2^32 by design.
            we       <= 1'b1;
            waddr    <= BASE_ADDR + byte_cnt;
            wdata    <= in_data;
            sum      <= sum + in_data;
            byte_cnt <= byte_cnt_next;
            if (last_payload) begin
              state <= ST_CSUM;
            end
          end
        end

        ST_CSUM: begin
          if (xfer) begin
            if (in_data == sum) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              // cpu_hold was set at start and simply stays high.
              state <= ST_ERR;
              err   <= 1'b1;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed bench for imem_loader. Payload writes are predicted into exp_q
// as they are driven; an independent monitor pops one entry per we pulse
// and compares address and data. Status outputs are checked at the end of
// each frame against hand-computed values.
// ---------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam logic [2:0]  ST_IDLE = 3'd0;

  // ---------------------------------------------------------------- clock/reset
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        we;
  logic [31:0] waddr;
  logic [7:0]  wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] byte_cnt;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  imem_loader #(
    .BASE_ADDR (BASE),
    .MAX_BYTES (4096),
    .HOLD_RST  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .byte_cnt  (byte_cnt),
    .state_dbg (state_dbg)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [39:0] exp_q[$];   // {address, data} of each expected write
  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: every write pulse must match the oldest predicted write.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_we: got write addr %0h data %0h, expected no write", waddr, wdata);
      end else begin
        logic [39:0] e;
        e = exp_q.pop_front();
        check("we_addr", waddr, e[39:8]);
        check("we_data", {24'd0, wdata}, {24'd0, e[7:0]});
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one byte and hold it until the loader takes it.
  task automatic send_byte(input logic [7:0] b);
    int wait_cyc;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    wait_cyc = 0;
    while (in_ready !== 1'b1 && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    if (in_ready !== 1'b1) begin
      chk_cnt++;
      $display("FAIL ready_timeout: got in_ready=%0b after 50 cycles, expected 1", in_ready);
    end
    @(posedge clk);
  endtask

  // Payload byte k: predict its write, then send it.
  task automatic send_payload(input int k, input logic [7:0] b);
    exp_q.push_back({BASE + 32'(k), b});
    send_byte(b);
  endtask

  task automatic send_len(input logic [31:0] n);
    send_byte(n[31:24]);
    send_byte(n[23:16]);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic check_end(input string tag, input logic e_done, input logic e_err,
                           input logic e_hold, input logic [31:0] e_cnt);
    check({tag, "_done"},     {31'd0, done},     {31'd0, e_done});
    check({tag, "_err"},      {31'd0, err},      {31'd0, e_err});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, e_hold});
    check({tag, "_byte_cnt"}, byte_cnt,          e_cnt);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_pending"},  32'(exp_q.size()), 32'd0);
  endtask

  // Overall guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected earlier finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;

    // Reset held for two cycles.
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",       {31'd0, we},       32'd0);
    check("rst_waddr",    waddr,             32'd0);
    check("rst_wdata",    {24'd0, wdata},    32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_done",     {31'd0, done},     32'd0);
    check("rst_err",      {31'd0, err},      32'd0);
    check("rst_byte_cnt", byte_cnt,          32'd0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    check("rst_state",    {29'd0, state_dbg}, {29'd0, ST_IDLE});
    rst = 1'b0;
    idle(2);

    // Good frame: 13+05+00+00 = 18.
    do_start();
    check("len_busy",  {31'd0, busy},     32'd1);
    check("len_ready", {31'd0, in_ready}, 32'd1);
    send_len(32'd4);
    send_payload(0, 8'h13);
    send_payload(1, 8'h05);
    send_payload(2, 8'h00);
    send_payload(3, 8'h00);
    send_byte(8'h18);
    idle(1);
    check_end("good", 1'b1, 1'b0, 1'b0, 32'd4);
    check("good_ready", {31'd0, in_ready}, 32'd0);

    // Same frame, wrong checksum.
    do_start();
    check("restart_done_clr", {31'd0, done}, 32'd0);
    check("restart_hold",     {31'd0, cpu_hold}, 32'd1);
    send_len(32'd4);
    send_payload(0, 8'h13);
    send_payload(1, 8'h05);
    send_payload(2, 8'h00);
    send_payload(3, 8'h00);
    send_byte(8'h19);
    idle(1);
    check_end("badsum", 1'b0, 1'b1, 1'b1, 32'd4);

    // Backpressure: valid drops between payload bytes; a start pulse in the
    // middle of the frame must be ignored.
    do_start();
    send_len(32'd4);
    send_payload(0, 8'h13);
    idle(1);
    send_payload(1, 8'h05);
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    check("midframe_start_busy", {31'd0, busy}, 32'd1);
    send_payload(2, 8'h00);
    idle(1);
    send_payload(3, 8'h00);
    idle(1);
    send_byte(8'h18);
    idle(1);
    check_end("bp", 1'b1, 1'b0, 1'b0, 32'd4);

    // N = 6 is not a multiple of 4.
    do_start();
    send_len(32'd6);
    idle(1);
    check_end("len6", 1'b0, 1'b1, 1'b1, 32'd0);
    check("len6_ready", {31'd0, in_ready}, 32'd0);

    // N = MAX_BYTES + 4: rejected, later bytes are not consumed or written.
    do_start();
    send_len(32'd4100);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    idle(4);
    check_end("lenmax", 1'b0, 1'b1, 1'b1, 32'd0);

    // N = 0 with checksum 00.
    do_start();
    send_len(32'd0);
    send_byte(8'h00);
    idle(1);
    check_end("len0", 1'b1, 1'b0, 1'b0, 32'd0);

    // Reset in the middle of the payload, with a byte still offered.
    do_start();
    send_len(32'd8);
    send_payload(0, 8'hAA);
    send_payload(1, 8'hBB);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hCC;
    rst      = 1'b1;
    @(negedge clk);
    check("mrst_state",    {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check("mrst_busy",     {31'd0, busy},      32'd0);
    check("mrst_we",       {31'd0, we},        32'd0);
    check("mrst_cpu_hold", {31'd0, cpu_hold},  32'd1);
    check("mrst_byte_cnt", byte_cnt,           32'd0);
    rst = 1'b0;
    idle(4);
    check("mrst_pending", 32'(exp_q.size()), 32'd0);

    // Recovery frame, 8 bytes: 4*FF + 01+02+03+04 = 0x406 -> 06.
    do_start();
    send_len(32'd8);
    send_payload(0, 8'hFF);
    send_payload(1, 8'hFF);
    send_payload(2, 8'hFF);
    send_payload(3, 8'hFF);
    send_payload(4, 8'h01);
    send_payload(5, 8'h02);
    send_payload(6, 8'h03);
    send_payload(7, 8'h04);
    send_byte(8'h06);
    idle(3);
    check_end("recover", 1'b1, 1'b0, 1'b0, 32'd8);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
